// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its MEM/WB register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_stage_pkg;

    localparam int          DATA_W      = 32;
    localparam int          ACC_W       = 64;
    localparam int          REG_W       = 5;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memread;
        logic              acc;
        logic [REG_W-1:0]  reg_dst;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] mem_data;
        logic [ACC_W-1:0]  accumulator;
    } wb_t;

    // A bubble only kills the side-effecting bits; everything else is held.
    function automatic wb_t wb_bubble(input wb_t held);
        wb_t b;
        b          = held;
        b.regwrite = 1'b0;
        b.acc      = 1'b0;
        b.memread  = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register with explicit load and bubble controls.
// Latency: 1 cycle from load/bubble to q.
// Backpressure: none; neither load nor bubble holds the register unchanged.
module mem_wb
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic load,
    input  logic bubble,
    input  wb_t  d,
    output wb_t  q
);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (bubble) begin
            q <= wb_bubble(q);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: single data-memory transaction per instruction, MEM/WB register, accumulator.
// Latency: 1 cycle for non-memory ops; loads/stores retire on the edge where dmem_ready is seen.
// Backpressure: stall holds upstream while a transaction is pending; timeout aborts with err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_acc,
    input  logic [REG_W-1:0]  ex_reg_dst,
    input  logic [DATA_W-1:0] ex_alures,
    input  logic [DATA_W-1:0] ex_read_reg_2_data,
    input  logic [ACC_W-1:0]  ex_accumulator,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic              wb_memread,
    output logic              wb_acc,
    output logic [REG_W-1:0]  wb_reg_dst,
    output logic [DATA_W-1:0] wb_alures,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [ACC_W-1:0]  wb_accumulator,
    output logic [ACC_W-1:0]  acc_reg,
    output logic              err
);

    localparam int          CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              we_q;
    logic              err_q;
    logic [ACC_W-1:0]  acc_q;

    logic mem_op, aligned, access, illegal, at_limit;
    logic stall_c, wb_load, wb_bub, latch_en, cnt_inc, set_err;
    wb_t  wb_d, wb_q;

    assign mem_op   = ex_memread | ex_memwrite;
    assign aligned  = (ex_alures[1:0] == 2'b00);
    assign access   = (ex_memread ^ ex_memwrite) & aligned;
    assign illegal  = mem_op & ~access;
    assign at_limit = (cnt == CNT_W'(CNT_LAST));

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        wb_load   = 1'b0;
        wb_bub    = 1'b0;
        latch_en  = 1'b0;
        cnt_inc   = 1'b0;
        set_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stall_c   = 1'b1;
                    latch_en  = 1'b1;
                    wb_bub    = 1'b1;
                    state_nxt = ST_WAIT;
                end else if (illegal) begin
                    set_err = 1'b1;
                    wb_bub  = 1'b1;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_WAIT: begin
                // Ready wins over the timeout when both land in the same cycle.
                if (dmem_ready) begin
                    wb_load   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (at_limit) begin
                    set_err   = 1'b1;
                    wb_bub    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_inc = 1'b1;
                    wb_bub  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                cnt     <= '0;
                addr_q  <= ex_alures;
                wdata_q <= ex_read_reg_2_data;
                we_q    <= ex_memwrite;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (wb_load && ex_acc) begin
                acc_q <= ex_accumulator;
            end
        end
    end

    // EX/MEM is frozen while stalled, so ex_* still describes the pending instruction.
    always_comb begin
        wb_d             = '0;
        wb_d.regwrite    = ex_regwrite;
        wb_d.memtoreg    = ex_memtoreg;
        wb_d.memread     = ex_memread;
        wb_d.acc         = ex_acc;
        wb_d.reg_dst     = ex_reg_dst;
        wb_d.alures      = ex_alures;
        wb_d.mem_data    = (state == ST_WAIT && !we_q) ? dmem_rdata : '0;
        wb_d.accumulator = ex_accumulator;
    end

    mem_wb u_mem_wb (
        .clk    (clk),
        .res    (res),
        .load   (wb_load),
        .bubble (wb_bub),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign dmem_req       = (state == ST_WAIT);
    assign dmem_we        = dmem_req & we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign stall          = stall_c & res;
    assign err            = err_q;
    assign acc_reg        = acc_q;
    assign wb_regwrite    = wb_q.regwrite;
    assign wb_memtoreg    = wb_q.memtoreg;
    assign wb_memread     = wb_q.memread;
    assign wb_acc         = wb_q.acc;
    assign wb_reg_dst     = wb_q.reg_dst;
    assign wb_alures      = wb_q.alures;
    assign wb_mem_data    = wb_q.mem_data;
    assign wb_accumulator = wb_q.accumulator;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1-3 ns after it.
module tb_mem_stage;

    logic        clk;
    logic        res;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_acc;
    logic [4:0]  ex_reg_dst;
    logic [31:0] ex_alures, ex_read_reg_2_data;
    logic [63:0] ex_accumulator;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall;
    logic        wb_regwrite, wb_memtoreg, wb_memread, wb_acc;
    logic [4:0]  wb_reg_dst;
    logic [31:0] wb_alures, wb_mem_data;
    logic [63:0] wb_accumulator, acc_reg;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_cyc;
    int req_cyc;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .res                (res),
        .ex_regwrite        (ex_regwrite),
        .ex_memread         (ex_memread),
        .ex_memwrite        (ex_memwrite),
        .ex_memtoreg        (ex_memtoreg),
        .ex_acc             (ex_acc),
        .ex_reg_dst         (ex_reg_dst),
        .ex_alures          (ex_alures),
        .ex_read_reg_2_data (ex_read_reg_2_data),
        .ex_accumulator     (ex_accumulator),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ready         (dmem_ready),
        .dmem_rdata         (dmem_rdata),
        .stall              (stall),
        .wb_regwrite        (wb_regwrite),
        .wb_memtoreg        (wb_memtoreg),
        .wb_memread         (wb_memread),
        .wb_acc             (wb_acc),
        .wb_reg_dst         (wb_reg_dst),
        .wb_alures          (wb_alures),
        .wb_mem_data        (wb_mem_data),
        .wb_accumulator     (wb_accumulator),
        .acc_reg            (acc_reg),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic nop();
        ex_regwrite        = 1'b0;
        ex_memread         = 1'b0;
        ex_memwrite        = 1'b0;
        ex_memtoreg        = 1'b0;
        ex_acc             = 1'b0;
        ex_reg_dst         = 5'd0;
        ex_alures          = 32'd0;
        ex_read_reg_2_data = 32'd0;
        ex_accumulator     = 64'd0;
    endtask

    initial begin
        res        = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        nop();
        // An aligned load presented during reset must not stall or request.
        ex_memread = 1'b1;
        ex_alures  = 32'h100;
        #12;
        chk("rst_stall",  64'(stall),       64'(0));
        chk("rst_req",    64'(dmem_req),    64'(0));
        chk("rst_we",     64'(dmem_we),     64'(0));
        chk("rst_wb_rw",  64'(wb_regwrite), 64'(0));
        chk("rst_wb_alu", 64'(wb_alures),   64'(0));
        chk("rst_acc",    acc_reg,          64'(0));
        chk("rst_err",    64'(err),         64'(0));
        nop();
        tick();
        res = 1'b1;
        tick();

        // ALU op
        ex_regwrite = 1'b1;
        ex_reg_dst  = 5'd5;
        ex_alures   = 32'h10;
        settle();
        chk("alu_stall", 64'(stall), 64'(0));
        tick();
        chk("alu_wb_rw",  64'(wb_regwrite), 64'(1));
        chk("alu_wb_dst", 64'(wb_reg_dst),  64'(5));
        chk("alu_wb_res", 64'(wb_alures),   64'(32'h10));
        chk("alu_stall2", 64'(stall),       64'(0));
        nop();
        tick();

        // Load, ready after 3 WAIT cycles
        ex_memread  = 1'b1;
        ex_memtoreg = 1'b1;
        ex_regwrite = 1'b1;
        ex_reg_dst  = 5'd7;
        ex_alures   = 32'h100;
        dmem_rdata  = 32'hCAFE_0001;
        settle();
        chk("ld_idle_req", 64'(dmem_req), 64'(0));
        stall_cyc = int'(stall);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_wait_req",  64'(dmem_req),    64'(1));
            chk("ld_wait_addr", 64'(dmem_addr),   64'(32'h100));
            chk("ld_wait_we",   64'(dmem_we),     64'(0));
            chk("ld_wait_wbrw", 64'(wb_regwrite), 64'(0));
            stall_cyc += int'(stall);
        end
        tick();
        dmem_ready = 1'b1;
        settle();
        chk("ld_rdy_stall", 64'(stall),     64'(0));
        chk("ld_rdy_addr",  64'(dmem_addr), 64'(32'h100));
        stall_cyc += int'(stall);
        tick();
        nop();
        dmem_ready = 1'b0;
        chk("ld_wb_data", 64'(wb_mem_data), 64'(32'hCAFE_0001));
        chk("ld_wb_mrd",  64'(wb_memread),  64'(1));
        chk("ld_wb_rw",   64'(wb_regwrite), 64'(1));
        chk("ld_wb_dst",  64'(wb_reg_dst),  64'(7));
        chk("ld_req_off", 64'(dmem_req),    64'(0));
        chk("ld_stall_n", 64'(stall_cyc),   64'(4));

        // Store, ready on the first WAIT cycle
        ex_memwrite        = 1'b1;
        ex_alures          = 32'h204;
        ex_read_reg_2_data = 32'h55;
        dmem_ready         = 1'b1;
        settle();
        chk("st_idle_stall", 64'(stall),    64'(1));
        chk("st_idle_req",   64'(dmem_req), 64'(0));
        chk("st_idle_we",    64'(dmem_we),  64'(0));
        tick();
        chk("st_req",   64'(dmem_req),   64'(1));
        chk("st_we",    64'(dmem_we),    64'(1));
        chk("st_wdata", 64'(dmem_wdata), 64'(32'h55));
        chk("st_addr",  64'(dmem_addr),  64'(32'h204));
        chk("st_stall", 64'(stall),      64'(0));
        tick();
        nop();
        dmem_ready = 1'b0;
        chk("st_req_off", 64'(dmem_req),    64'(0));
        chk("st_we_off",  64'(dmem_we),     64'(0));
        chk("st_wb_rw",   64'(wb_regwrite), 64'(0));
        chk("st_wb_data", 64'(wb_mem_data), 64'(0));
        chk("st_err",     64'(err),         64'(0));

        // Misaligned load; ex_acc set to prove a bubble never loads acc_reg
        ex_memread     = 1'b1;
        ex_regwrite    = 1'b1;
        ex_reg_dst     = 5'd9;
        ex_alures      = 32'h103;
        ex_acc         = 1'b1;
        ex_accumulator = 64'hDEAD_BEEF;
        settle();
        chk("mis_stall", 64'(stall),    64'(0));
        chk("mis_req",   64'(dmem_req), 64'(0));
        tick();
        nop();
        chk("mis_err",    64'(err),         64'(1));
        chk("mis_wb_rw",  64'(wb_regwrite), 64'(0));
        chk("mis_wb_mrd", 64'(wb_memread),  64'(0));
        chk("mis_wb_acc", 64'(wb_acc),      64'(0));
        chk("mis_req2",   64'(dmem_req),    64'(0));
        chk("mis_acc",    acc_reg,          64'(0));

        // Read and write together is illegal
        ex_memread  = 1'b1;
        ex_memwrite = 1'b1;
        ex_regwrite = 1'b1;
        ex_alures   = 32'h200;
        settle();
        chk("ill_stall", 64'(stall),    64'(0));
        chk("ill_req",   64'(dmem_req), 64'(0));
        tick();
        nop();
        chk("ill_wb_rw", 64'(wb_regwrite), 64'(0));
        chk("ill_req2",  64'(dmem_req),    64'(0));
        tick();
        tick();
        chk("err_sticky", 64'(err), 64'(1));

        // Reset clears err before the timeout scenario
        res = 1'b0;
        #1;
        chk("rst2_err", 64'(err), 64'(0));
        tick();
        res = 1'b1;
        tick();

        // Timeout: ready never arrives
        ex_memread  = 1'b1;
        ex_regwrite = 1'b1;
        ex_alures   = 32'h300;
        settle();
        chk("to_idle_stall", 64'(stall), 64'(1));
        req_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_stall", 64'(stall),     64'(1));
            chk("to_wait_addr",  64'(dmem_addr), 64'(32'h300));
            req_cyc += int'(dmem_req);
        end
        tick();
        chk("to_abort_stall", 64'(stall), 64'(0));
        chk("to_abort_err0",  64'(err),   64'(0));
        req_cyc += int'(dmem_req);
        tick();
        nop();
        ex_regwrite = 1'b1;
        ex_reg_dst  = 5'd3;
        ex_alures   = 32'hABC;
        chk("to_req_cyc", 64'(req_cyc),     64'(4));
        chk("to_req_off", 64'(dmem_req),    64'(0));
        chk("to_err",     64'(err),         64'(1));
        chk("to_wb_rw",   64'(wb_regwrite), 64'(0));
        settle();
        chk("to_next_stall", 64'(stall), 64'(0));
        tick();
        nop();
        chk("to_next_rw",  64'(wb_regwrite), 64'(1));
        chk("to_next_dst", 64'(wb_reg_dst),  64'(3));
        chk("to_next_res", 64'(wb_alures),   64'(32'hABC));

        // Accumulator update
        ex_acc         = 1'b1;
        ex_accumulator = 64'h1_0000_0002;
        tick();
        nop();
        chk("acc_reg",    acc_reg,          64'h1_0000_0002);
        chk("acc_wb_acc", 64'(wb_acc),      64'(1));
        chk("acc_wb_val", wb_accumulator,   64'h1_0000_0002);
        tick();
        chk("acc_hold",   acc_reg,          64'h1_0000_0002);

        // Reset asserted mid-WAIT
        ex_memread  = 1'b1;
        ex_regwrite = 1'b1;
        ex_alures   = 32'h400;
        tick();
        chk("mw_req", 64'(dmem_req), 64'(1));
        chk("mw_err", 64'(err),      64'(1));
        #1;
        res = 1'b0;
        #1;
        chk("mw_rst_req",   64'(dmem_req),    64'(0));
        chk("mw_rst_acc",   acc_reg,          64'(0));
        chk("mw_rst_err",   64'(err),         64'(0));
        chk("mw_rst_stall", 64'(stall),       64'(0));
        chk("mw_rst_wbrw",  64'(wb_regwrite), 64'(0));
        nop();
        tick();
        res = 1'b1;
        tick();
        chk("mw_post_req",   64'(dmem_req), 64'(0));
        chk("mw_post_stall", 64'(stall),    64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
